// File: rtl/i2s_tx_sched_if.sv
// Bundled signals between the sample sources, the I2S transmitter and the frame scheduler.
// The scheduler connects through `slave`; whatever drives the sources and control uses `master`.
interface i2s_tx_sched_if #(
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned D_WIDTH = 16
);
    localparam int unsigned GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic                       enable;
    logic                       mute;
    logic [7:0]                 bclk_period_cfg;
    logic [N_SRC-1:0]           src_vld;
    logic [N_SRC*D_WIDTH-1:0]   src_data;
    logic [N_SRC-1:0]           src_rdy;
    logic [7:0]                 bclk_period;
    logic                       sample_vld;
    logic [D_WIDTH-1:0]         sample;
    logic [GW-1:0]              grant_id;
    logic                       underrun;
    logic [7:0]                 underrun_cnt;
    logic                       busy;

    modport slave (
        input  enable, mute, bclk_period_cfg, src_vld, src_data,
        output src_rdy, bclk_period, sample_vld, sample, grant_id, underrun, underrun_cnt, busy
    );

    modport master (
        output enable, mute, bclk_period_cfg, src_vld, src_data,
        input  src_rdy, bclk_period, sample_vld, sample, grant_id, underrun, underrun_cnt, busy
    );
endinterface

// File: rtl/i2s_tx_sched.sv
// Frame-paced round-robin scheduler feeding one I2S transmitter sample port.
// One tick per 64*P-cycle frame grants a source (or fills zero and counts an underrun).
module i2s_tx_sched #(
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned D_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    i2s_tx_sched_if.slave     bus
);
    localparam int unsigned GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e               state_q, state_d;
    logic [13:0]          tcnt_q, tcnt_d;
    logic [7:0]           period_q, period_d;
    logic                 first_q, first_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic                 sample_vld_q, sample_vld_d;
    logic [D_WIDTH-1:0]   sample_q, sample_d;
    logic                 underrun_q, underrun_d;
    logic [7:0]           underrun_cnt_q, underrun_cnt_d;

    logic                 tick;
    logic                 found;
    logic [GW-1:0]        grant;
    logic [N_SRC-1:0]     src_rdy;
    logic [13:0]          frame_last;
    logic                 wrap;
    logic [7:0]           period_cfg;

    assign frame_last = {period_q, 6'b0} - 14'd1;
    assign wrap       = (tcnt_q == frame_last);
    assign period_cfg = (bus.bclk_period_cfg < 8'd2) ? 8'd2 : bus.bclk_period_cfg;

    // First valid source at or after ptr, wrapping modulo N_SRC.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (int'(ptr_q) + k) % N_SRC;
            if (!found && bus.src_vld[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        tcnt_d         = tcnt_q;
        period_d       = period_q;
        first_d        = 1'b0;
        ptr_d          = ptr_q;
        grant_id_d     = grant_id_q;
        sample_vld_d   = 1'b0;
        sample_d       = sample_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        tick           = 1'b0;
        src_rdy        = '0;

        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (bus.enable) begin
                    period_d = period_cfg;
                    state_d  = StRun;
                    first_d  = 1'b1;
                end
            end
            StRun: begin
                tcnt_d = (first_q || wrap) ? 14'd0 : tcnt_q + 14'd1;
                if (wrap) period_d = period_cfg;
                if (!bus.enable) begin
                    state_d = StStop;
                end else begin
                    tick = first_q || wrap;
                end
            end
            StStop: begin
                if (wrap) begin
                    // Either resume at this boundary or park until the next enable.
                    tcnt_d = '0;
                    if (bus.enable) begin
                        period_d = period_cfg;
                        state_d  = StRun;
                        tick     = 1'b1;
                    end else begin
                        state_d  = StIdle;
                    end
                end else begin
                    tcnt_d = tcnt_q + 14'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tick) begin
            sample_vld_d = 1'b1;
            if (found) begin
                src_rdy    = N_SRC'(1) << grant;
                sample_d   = bus.mute ? '0 : bus.src_data[int'(grant)*D_WIDTH +: D_WIDTH];
                ptr_d      = (int'(grant) == N_SRC - 1) ? '0 : grant + GW'(1);
                grant_id_d = grant;
            end else begin
                sample_d   = '0;
                underrun_d = 1'b1;
                if (underrun_cnt_q != 8'hff) underrun_cnt_d = underrun_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            tcnt_q         <= '0;
            period_q       <= 8'd2;
            first_q        <= 1'b0;
            ptr_q          <= '0;
            grant_id_q     <= '0;
            sample_vld_q   <= 1'b0;
            sample_q       <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            tcnt_q         <= tcnt_d;
            period_q       <= period_d;
            first_q        <= first_d;
            ptr_q          <= ptr_d;
            grant_id_q     <= grant_id_d;
            sample_vld_q   <= sample_vld_d;
            sample_q       <= sample_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign bus.src_rdy      = src_rdy;
    assign bus.bclk_period  = period_q;
    assign bus.sample_vld   = sample_vld_q;
    assign bus.sample       = sample_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = underrun_cnt_q;
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_i2s_tx_sched.sv
// Directed bench for i2s_tx_sched: pacing, round robin, underrun, period change, disable, mute, reset.
module tb_i2s_tx_sched;
    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    i2s_tx_sched_if #(.N_SRC(2), .D_WIDTH(16)) bus ();

    i2s_tx_sched #(.N_SRC(2), .D_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic wait_vld(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            if (bus.sample_vld) ok = 1'b1;
            i++;
        end
    endtask

    task automatic wait_rdy(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            if (bus.src_rdy != 2'b00) ok = 1'b1;
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.mute = 1'b0;
        bus.bclk_period_cfg = 8'd4;
        bus.src_vld = 2'b00;
        bus.src_data = {16'h2222, 16'h1111};
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.src_rdy, bus.sample_vld, bus.underrun, bus.busy, bus.grant_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b vld=%b urun=%b busy=%b gid=%0d want all 0",
                     bus.src_rdy, bus.sample_vld, bus.underrun, bus.busy, bus.grant_id);
        end
        checks++;
        if (bus.bclk_period !== 8'd2) begin
            errors++;
            $display("FAIL reset_period: got %0d want 2", bus.bclk_period);
        end
        checks++;
        if (bus.sample !== 16'h0 || bus.underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got sample=%h cnt=%0d want 0/0", bus.sample, bus.underrun_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int t_prev;
        logic [15:0] exp_s [3];
        logic        exp_g [3];
        exp_s[0] = 16'h1111; exp_s[1] = 16'h2222; exp_s[2] = 16'h1111;
        exp_g[0] = 1'b0;     exp_g[1] = 1'b1;     exp_g[2] = 1'b0;
        bus.src_vld = 2'b11;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.src_rdy !== 2'b01 || bus.busy !== 1'b1 || bus.bclk_period !== 8'd4) begin
            errors++;
            $display("FAIL rr_first_tick: got rdy=%b busy=%b per=%0d want 01/1/4",
                     bus.src_rdy, bus.busy, bus.bclk_period);
        end
        @(negedge clk);
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_vld(300, ok);
                checks++;
                if (!ok || cyc - t_prev != 256) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: got found=%0d gap=%0d want 1/256",
                             k, ok, cyc - t_prev);
                end
                t_prev = cyc;
            end
            checks++;
            if (bus.sample_vld !== 1'b1 || bus.sample !== exp_s[k] || bus.grant_id !== exp_g[k]) begin
                errors++;
                $display("FAIL rr_sample%0d: got vld=%b s=%h g=%0d want 1/%h/%0d",
                         k, bus.sample_vld, bus.sample, bus.grant_id, exp_s[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_single_source();
        bit ok;
        bus.src_vld = 2'b10;
        for (int k = 0; k < 3; k++) begin
            wait_rdy(300, ok);
            checks++;
            if (!ok || bus.src_rdy !== 2'b10) begin
                errors++;
                $display("FAIL single_rdy%0d: got found=%0d rdy=%b want 1/10", k, ok, bus.src_rdy);
            end
            @(negedge clk);
            checks++;
            if (bus.sample_vld !== 1'b1 || bus.sample !== 16'h2222 || bus.grant_id !== 1'b1) begin
                errors++;
                $display("FAIL single_sample%0d: got vld=%b s=%h g=%0d want 1/2222/1",
                         k, bus.sample_vld, bus.sample, bus.grant_id);
            end
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int bad;
        int seen;
        int t_prev;
        int exp_cnt;
        bad = 0;
        seen = 0;
        t_prev = 0;
        bus.src_vld = 2'b00;
        bus.bclk_period_cfg = 8'd0;
        for (int k = 1; k <= 300; k++) begin
            wait_vld(300, ok);
            if (!ok) begin
                bad++;
                break;
            end
            seen++;
            exp_cnt = (k > 255) ? 255 : k;
            if (bus.underrun !== 1'b1 || bus.sample !== 16'h0 || bus.src_rdy !== 2'b00 ||
                bus.underrun_cnt !== 8'(exp_cnt)) bad++;
            if (k >= 2 && cyc - t_prev != 128) bad++;
            t_prev = cyc;
        end
        checks++;
        if (bad != 0 || seen != 300) begin
            errors++;
            $display("FAIL underrun_frames: got bad=%0d seen=%0d want 0/300", bad, seen);
        end
        checks++;
        if (bus.underrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL underrun_sat: got %0d want 255", bus.underrun_cnt);
        end
        checks++;
        if (bus.bclk_period !== 8'd2) begin
            errors++;
            $display("FAIL clamp_period: got %0d want 2", bus.bclk_period);
        end
        @(negedge clk);
        checks++;
        if (bus.underrun !== 1'b0 || bus.sample_vld !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pulse: got urun=%b vld=%b want 0/0", bus.underrun, bus.sample_vld);
        end
    endtask

    task automatic test_period_change();
        bit ok;
        int t_prev;
        t_prev = cyc - 1;
        bus.bclk_period_cfg = 8'd8;
        bus.src_vld = 2'b11;
        wait_vld(300, ok);
        checks++;
        if (!ok || cyc - t_prev != 128) begin
            errors++;
            $display("FAIL per_old_frame: got found=%0d gap=%0d want 1/128", ok, cyc - t_prev);
        end
        checks++;
        if (bus.sample !== 16'h1111 || bus.grant_id !== 1'b0 || bus.underrun !== 1'b0 ||
            bus.bclk_period !== 8'd8 || bus.underrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL per_switch: got s=%h g=%0d urun=%b per=%0d cnt=%0d want 1111/0/0/8/255",
                     bus.sample, bus.grant_id, bus.underrun, bus.bclk_period, bus.underrun_cnt);
        end
        t_prev = cyc;
        wait_vld(600, ok);
        checks++;
        if (!ok || cyc - t_prev != 512 || bus.sample !== 16'h2222) begin
            errors++;
            $display("FAIL per_new_frame: got found=%0d gap=%0d s=%h want 1/512/2222",
                     ok, cyc - t_prev, bus.sample);
        end
    endtask

    task automatic test_disable();
        int c0;
        int vld_seen;
        bit fell;
        int fall_cyc;
        c0 = cyc;
        vld_seen = 0;
        fell = 1'b0;
        fall_cyc = 0;
        repeat (10) @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 1000 && !fell; i++) begin
            @(negedge clk);
            if (bus.sample_vld) vld_seen++;
            if (!bus.busy) begin
                fell = 1'b1;
                fall_cyc = cyc;
            end
        end
        checks++;
        if (!fell || fall_cyc != c0 + 512) begin
            errors++;
            $display("FAIL busy_fall: got fell=%0d at=%0d want 1 at %0d", fell, fall_cyc, c0 + 512);
        end
        checks++;
        if (vld_seen != 0) begin
            errors++;
            $display("FAIL stop_no_vld: got %0d pulses want 0", vld_seen);
        end
        repeat (5) @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.src_rdy !== 2'b01 || bus.sample_vld !== 1'b0) begin
            errors++;
            $display("FAIL reen_tick: got rdy=%b vld=%b want 01/0", bus.src_rdy, bus.sample_vld);
        end
        @(negedge clk);
        checks++;
        if (bus.sample_vld !== 1'b1 || bus.sample !== 16'h1111 || bus.bclk_period !== 8'd8) begin
            errors++;
            $display("FAIL reen_sample: got vld=%b s=%h per=%0d want 1/1111/8",
                     bus.sample_vld, bus.sample, bus.bclk_period);
        end
    endtask

    task automatic test_mute_reset();
        bit ok;
        bus.mute = 1'b1;
        wait_rdy(600, ok);
        checks++;
        if (!ok || bus.src_rdy !== 2'b10) begin
            errors++;
            $display("FAIL mute_rdy: got found=%0d rdy=%b want 1/10", ok, bus.src_rdy);
        end
        @(negedge clk);
        checks++;
        if (bus.sample_vld !== 1'b1 || bus.sample !== 16'h0 || bus.grant_id !== 1'b1) begin
            errors++;
            $display("FAIL mute_sample: got vld=%b s=%h g=%0d want 1/0000/1",
                     bus.sample_vld, bus.sample, bus.grant_id);
        end
        bus.mute = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.src_rdy, bus.sample_vld, bus.underrun, bus.busy, bus.grant_id} !== 6'b0 ||
            bus.sample !== 16'h0 || bus.underrun_cnt !== 8'd0 || bus.bclk_period !== 8'd2) begin
            errors++;
            $display("FAIL midframe_reset: got rdy=%b vld=%b busy=%b s=%h cnt=%0d per=%0d want 0s/per 2",
                     bus.src_rdy, bus.sample_vld, bus.busy, bus.sample, bus.underrun_cnt,
                     bus.bclk_period);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.src_rdy !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_ptr: got rdy=%b want 01", bus.src_rdy);
        end
        @(negedge clk);
        checks++;
        if (bus.sample_vld !== 1'b1 || bus.sample !== 16'h1111 || bus.grant_id !== 1'b0 ||
            bus.bclk_period !== 8'd8) begin
            errors++;
            $display("FAIL post_reset_sample: got vld=%b s=%h g=%0d per=%0d want 1/1111/0/8",
                     bus.sample_vld, bus.sample, bus.grant_id, bus.bclk_period);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_round_robin();
        test_single_source();
        test_underrun();
        test_period_change();
        test_disable();
        test_mute_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_tx_sched.md
# i2s_tx_sched

Frame-paced round-robin scheduler that shares the single sample port of the I2S transmitter between `N_SRC` upstream sample producers (e.g. anti-noise path, playback path). It owns the transmitter's bit-clock configuration, issues exactly one `sample_vld` pulse per I2S frame, and grants one source per frame in round-robin order. Frames in which no source has data are filled with zero, and each such frame is counted as an underrun. It sits directly upstream of the I2S transmitter and drives that transmitter's `bclk_period`, `sample_vld` and `sample` inputs.

## Interface
- `N_SRC`, default 2, number of requesting sources (2..8)
- `D_WIDTH`, default 16, sample width
- `clk`  in  1  system clock (~100 MHz)
- `rst`  in  1  reset, asynchronous, active-high
- `enable`  in  1  run request
- `mute`  in  1  when 1, granted data is consumed but replaced by zero on output
- `bclk_period_cfg`  in  8  requested bclk half period in clk cycles
- `src_vld`  in  N_SRC  per-source data valid
- `src_data`  in  N_SRC*D_WIDTH  source i occupies bits [i*D_WIDTH +: D_WIDTH]
- `src_rdy`  out  N_SRC  per-source accept; one-hot or zero
- `bclk_period`  out  8  period applied to the transmitter
- `sample_vld`  out  1  one-cycle pulse per frame
- `sample`  out  D_WIDTH  data qualified by `sample_vld`
- `grant_id`  out  $clog2(N_SRC)  source index of the last transfer
- `underrun`  out  1  one-cycle pulse: frame filled with zero
- `underrun_cnt`  out  8  saturating underrun count
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RUN, STOP.
- IDLE:
  - frame timer `tcnt` held at 0; `src_rdy`=0.
  - On `enable`=1: latch period P = max(`bclk_period_cfg`, 2) into `bclk_period`, then go to RUN.
  - The first cycle in RUN is a tick.
- RUN:
  - Frame length L = {P, 6'b0} (14 bits) = 64·P cycles.
  - `tcnt` counts 0..L-1 and wraps.
  - Tick occurs at the first RUN cycle and at every cycle with `tcnt`==L-1.
  - At a frame wrap, P is re-latched from `bclk_period_cfg` (clamped). Configuration changes never take effect mid-frame.
- Arbitration on a tick cycle:
  - Grant g is the first index with `src_vld`=1, searching from pointer `ptr` upward and wrapping modulo N_SRC.
  - `src_rdy[g]`=1 for that cycle only (combinational from `src_vld`, state and tick). The transfer completes that cycle.
  - On a transfer: `ptr` <= g+1 mod N_SRC; `grant_id` <= g.
  - No valid source: no `src_rdy`; `ptr` is unchanged; output data is zero; `underrun` pulses; `underrun_cnt` increments, saturating at 255.
- Output on the cycle after a tick: `sample_vld`=1 and `sample` = (mute ? 0 : `src_data[g]`), or 0 on underrun.
- `src_rdy` is never asserted outside a tick. Sources must hold data while `src_vld`=1 and `src_rdy`=0.
- Disable:
  - `enable`=0 in RUN → STOP. No further ticks; `tcnt` keeps counting.
  - STOP → IDLE when `tcnt` reaches L-1, so `bclk_period` stays stable through the frame.
  - `enable`=1 in STOP → back to RUN at that frame boundary. That boundary is a tick.
- `rst` at any time returns to IDLE immediately. In-flight grants are discarded and no partial pulse is emitted.

## Timing
- Reset values:
  - `src_rdy`=0, `sample_vld`=0, `sample`=0, `grant_id`=0, `underrun`=0, `underrun_cnt`=0, `busy`=0, `bclk_period`=8'd2.
  - Internal: `ptr`=0, `tcnt`=0.
- Latency:
  - `enable` rising at cycle E → first tick at E+1 and first `sample_vld` at E+2.
  - Source handshake at tick cycle T → `sample_vld` at T+1.
- Spacing: consecutive `sample_vld` pulses are exactly L cycles apart while P is constant.
- Spacing across a period change: the frame after the change lasts L' = 64·P'.
- The `tcnt` compare uses the 14-bit L. P=255 gives L=16320, which fits without overflow.
- `underrun` and `sample_vld` assert in the same cycle.

## Test plan
- Reset, P_cfg=4, both sources always valid with constant data 0x1111 / 0x2222 → `sample_vld` every 256 cycles, alternating 0x1111, 0x2222, 0x1111; `grant_id` alternates 0,1,0.
- Only source 1 valid, N_SRC=2 → every frame grants 1, `src_rdy`=2'b10 on each tick; `ptr` behaviour does not starve it.
- No source valid for 300 frames → 300 zero samples; `underrun` pulses each frame; `underrun_cnt` saturates at 255.
- P_cfg changed from 4 to 8 mid-frame → current frame still 256 cycles, next frames 512 cycles; P_cfg=0 or 1 → 128-cycle frames.
- `enable` dropped 10 cycles into a frame → no further `sample_vld`; `busy` falls at the frame end; re-enable in IDLE restarts with a `sample_vld` 2 cycles later.
- `mute`=1 with valid sources → `src_rdy` handshakes still occur, `sample`=0; `rst` pulsed mid-frame → all outputs at reset values next cycle, `underrun_cnt`=0.
